// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and default timing for the button conditioning block.
//   rep_state_t        : auto-repeat FSM state per channel
//   *_40M constants    : default cycle counts for a 40 MHz system clock
//   max2()             : helper used to size the repeat counter
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam int DEBOUNCE_CYC_40M  = 400000;    // 10 ms
  localparam int REPEAT_DELAY_40M  = 20000000;  // 0.5 s
  localparam int REPEAT_PERIOD_40M = 4000000;   // 0.1 s

  function automatic int max2(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchroniser, debounce counter and auto-repeat FSM.
// Ports:
//   clk          in  system clock
//   rst          in  synchronous reset, active high
//   btn_raw      in  raw asynchronous button, active high
//   btn_level    out debounced level
//   btn_press    out 1-cycle pulse when a 0->1 change is accepted
//   btn_release  out 1-cycle pulse when a 1->0 change is accepted
//   btn_repeat   out 1-cycle auto-repeat pulse while held
// All outputs are registered.
// -----------------------------------------------------------------------------
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_40M,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_40M,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_40M
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int RCNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RP_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              accept_s;

  rep_state_t        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              repeat_q, repeat_d;

  // Synchroniser and debounce: count cycles the synced input disagrees with the
  // accepted level; any agreeing cycle restarts the count. Using >= on the
  // terminal value keeps the counter saturating rather than wrapping.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    accept_s = 1'b0;
    level_d  = level_q;
    cnt_d    = cnt_q;
    if (sync2_q != level_q) begin
      if (cnt_q >= DB_LAST) begin
        accept_s = 1'b1;
        level_d  = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    press_d   = accept_s & sync2_q;
    release_d = accept_s & ~sync2_q;
  end

  // Synchroniser, debounce counter, level and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Repeat FSM state register (repeat pulse is registered alongside).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      repeat_q <= repeat_d;
    end
  end

  // Repeat FSM next state; an accepted release wins over any timer expiry.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        rcnt_d = '0;
        if (press_d) begin
          state_d = DELAY;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q >= RD_LAST) begin
          state_d = REPEAT;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      REPEAT: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q >= RP_LAST) begin
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // Repeat FSM output: pulse on timer expiry unless the button is being released.
  always_comb begin
    repeat_d = 1'b0;
    if (release_d) begin
      repeat_d = 1'b0;
    end else begin
      case (state_q)
        DELAY:   repeat_d = (rcnt_q >= RD_LAST);
        REPEAT:  repeat_d = (rcnt_q >= RP_LAST);
        default: repeat_d = 1'b0;
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions N_BTN raw board buttons for the game logic: each channel is
// synchronised, debounced and given press/release/auto-repeat pulses.
// Ports:
//   clk          in  system clock (40 MHz)
//   rst          in  synchronous reset, active high
//   btnS         in  [N_BTN] raw asynchronous buttons, active high
//   btn_level    out [N_BTN] debounced level
//   btn_press    out [N_BTN] 1-cycle pulse on accepted 0->1
//   btn_release  out [N_BTN] 1-cycle pulse on accepted 1->0
//   btn_repeat   out [N_BTN] 1-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN         = 3,
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_40M,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_40M,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_40M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btnS,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  // Zero-length timings would make the terminal-count compares meaningless.
  if (N_BTN < 1 || DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_chk
    $error("btn_debounce: N_BTN and all timing parameters must be >= 1");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btnS[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Self-checking bench for btn_debounce with short timings (8 / 20 / 5).
// A behavioural model predicts every output on every cycle; directed sequences
// additionally check absolute latencies against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

  localparam int NB = 3;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btnS;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  btn_debounce #(
    .N_BTN         (NB),
    .DEBOUNCE_CYC  (D),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btnS        (btnS),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // The synced input seen by the debouncer is the raw input two edges late
  // (both pipeline stages forced to 0 by reset). A change is accepted once the
  // last D synced samples all disagree with the current level. Repeat pulses
  // fall at RD, RD+RP, RD+2RP ... edges after the press, unless released.
  logic [NB-1:0] m_p, m_q, m_lvl, e_press, e_rel, e_rep;
  logic [D-1:0]  hist [NB];
  int            hlen [NB];
  int            held [NB];

  task automatic model_edge();
    for (int c = 0; c < NB; c++) begin
      e_press[c] = 1'b0;
      e_rel[c]   = 1'b0;
      e_rep[c]   = 1'b0;
      if (rst) begin
        m_p[c] = 1'b0; m_q[c] = 1'b0; m_lvl[c] = 1'b0;
        hist[c] = '0; hlen[c] = 0; held[c] = -1;
      end else begin
        hist[c] = {hist[c][D-2:0], m_q[c]};
        if (hlen[c] < D) hlen[c]++;
        m_q[c] = m_p[c];
        m_p[c] = btnS[c];
        if (hlen[c] == D && hist[c] == {D{~m_lvl[c]}}) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            e_press[c] = 1'b1; held[c] = 0;
          end else begin
            e_rel[c] = 1'b1; held[c] = -1;
          end
        end else if (held[c] >= 0) begin
          held[c]++;
          if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0)) e_rep[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge,
  // compare just after it.
  task automatic step(input logic r, input logic [NB-1:0] b);
    @(negedge clk);
    rst  = r;
    btnS = b;
    @(posedge clk);
    model_edge();
    #1;
    chk("model", 32'({btn_level, btn_press, btn_release, btn_repeat}),
        32'({m_lvl, e_press, e_rel, e_rep}));
  endtask

  typedef struct {
    logic          rst;
    logic [NB-1:0] btn;
    int            cyc;
    logic [NB-1:0] exp_lvl;
  } vec_t;

  vec_t vt [0:8];
  int first, cnt, last, rel_at, bad_gap;
  logic [NB-1:0] rb;
  int hold_left [NB];

  initial begin
    rst  = 1'b1;
    btnS = '0;

    vt[0] = '{1'b1, 3'b000, 2,  3'b000};  // reset
    vt[1] = '{1'b0, 3'b000, 50, 3'b000};  // idle, no pulses
    vt[2] = '{1'b0, 3'b001, 12, 3'b001};
    vt[3] = '{1'b0, 3'b000, 12, 3'b000};
    vt[4] = '{1'b0, 3'b110, 12, 3'b110};
    vt[5] = '{1'b0, 3'b000, 12, 3'b000};
    vt[6] = '{1'b0, 3'b001, 9,  3'b000};  // one cycle short of acceptance
    vt[7] = '{1'b0, 3'b001, 1,  3'b001};  // accepted on the 10th cycle
    vt[8] = '{1'b0, 3'b000, 12, 3'b000};

    for (int r = 0; r <= 8; r++) begin
      for (int k = 0; k < vt[r].cyc; k++) step(vt[r].rst, vt[r].btn);
      chk($sformatf("tbl%0d_level", r), 32'(btn_level), 32'(vt[r].exp_lvl));
    end

    // Clean press / release on channel 0: 10 cycles each way.
    first = -1; cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 3'b001);
      if (btn_press[0]) begin cnt++; if (first < 0) first = i; end
    end
    chk("press0_latency", first, 10);
    chk("press0_count", cnt, 1);
    chk("level0_high", 32'(btn_level[0]), 1);
    first = -1; cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 3'b000);
      if (btn_release[0]) begin cnt++; if (first < 0) first = i; end
    end
    chk("release0_latency", first, 10);
    chk("release0_count", cnt, 1);

    // Bounce on channel 1: toggle every 3 cycles for 30, then steady high.
    first = -1; cnt = 0;
    for (int i = 0; i < 45; i++) begin
      step(1'b0, {1'b0, (i >= 30) ? 1'b1 : ((i / 3) % 2 == 0), 1'b0});
      if (btn_press[1]) begin cnt++; if (first < 0) first = i + 1; end
    end
    chk("bounce1_press_at", first, 40);
    chk("bounce1_press_count", cnt, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 3'b000);

    // Hold channel 2: press at 10, repeats at 30,35,...,75; release at 80
    // coincides with a repeat slot, which must be suppressed.
    first = -1; cnt = 0; last = -1; rel_at = -1; bad_gap = 0;
    for (int i = 1; i <= 90; i++) begin
      step(1'b0, (i <= 70) ? 3'b100 : 3'b000);
      if (btn_press[2]) first = i;
      if (btn_repeat[2]) begin
        if (i != 30 + 5 * cnt) bad_gap++;
        cnt++; last = i;
      end
      if (btn_release[2]) rel_at = i;
    end
    chk("hold2_press_at", first, 10);
    chk("hold2_repeat_count", cnt, 10);
    chk("hold2_repeat_spacing", bad_gap, 0);
    chk("hold2_last_repeat", last, 75);
    chk("hold2_release_at", rel_at, 80);

    // Simultaneous press on all channels, then a 5-cycle glitch.
    first = -1; cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 3'b111);
      if (btn_press == 3'b111 && first < 0) first = i;
      if (btn_press != 3'b000 && btn_press != 3'b111) cnt++;
    end
    chk("all_press_at", first, 10);
    chk("all_press_split", cnt, 0);
    for (int i = 0; i < 15; i++) step(1'b0, 3'b000);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, (i <= 5) ? 3'b001 : 3'b000);
      if ({btn_level, btn_press, btn_release, btn_repeat} != '0) cnt++;
    end
    chk("glitch_quiet", cnt, 0);

    // Reset mid-REPEAT with channel 0 held.
    for (int i = 1; i <= 33; i++) step(1'b0, 3'b001);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'b001);
      chk("rst_outputs_zero", 32'({btn_level, btn_press, btn_release, btn_repeat}), 0);
    end
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 3'b001);
      if (btn_release[0]) cnt++;
      if (btn_press[0] && first < 0) first = i;
    end
    chk("rst_no_release", cnt, 0);
    chk("rst_repress_at", first, 10);
    for (int i = 0; i < 15; i++) step(1'b0, 3'b000);

    // Randomised mix of glitches, long holds and rare resets against the model.
    rb = '0;
    for (int c = 0; c < NB; c++) hold_left[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold_left[c] == 0) begin
          rb[c] = ~rb[c];
          hold_left[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7))
                                                      : int'($urandom_range(8, 45));
        end else begin
          hold_left[c]--;
        end
      end
      step($urandom_range(0, 299) == 0, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
